// File: rtl/parking_time_tracker_if.sv
// Event/result bundle between the gate controller, the parking time tracker
// and the fee/display logic.
interface parking_time_tracker_if #(
  parameter int TW     = 8,
  parameter int SLOTS  = 4,
  parameter int SLOT_W = 2
);
  // Entry/exit events from the gate/sensor controller
  logic              enter_valid;
  logic [SLOT_W-1:0] enter_slot;
  logic              exit_valid;
  logic [SLOT_W-1:0] exit_slot;

  // Time base, occupancy and duration results
  logic [TW-1:0]     now;
  logic [SLOTS-1:0]  occupied;
  logic              dur_valid;
  logic [SLOT_W-1:0] dur_slot;
  logic [TW-1:0]     duration;
  logic              dur_sat;
  logic              err;

  // Controller side: issues events, observes results
  modport master (
    output enter_valid, enter_slot, exit_valid, exit_slot,
    input  now, occupied, dur_valid, dur_slot, duration, dur_sat, err
  );

  // Tracker side: consumes events, produces results
  modport slave (
    input  enter_valid, enter_slot, exit_valid, exit_slot,
    output now, occupied, dur_valid, dur_slot, duration, dur_sat, err
  );
endinterface

// File: rtl/parking_time_tracker.sv
// Multi-slot parking time tracker: free-running prescaled time base, one
// entry timestamp per slot, and a registered modulo-2^TW elapsed time on exit
// that saturates to all-ones once a slot has been held for a full wrap.
module parking_time_tracker #(
  parameter int TW       = 8,
  parameter int SLOTS    = 4,
  parameter int SLOT_W   = 2,
  parameter int TICK_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  parking_time_tracker_if.slave bus
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OCC  = 2'd1,
    SAT  = 2'd2
  } slot_state_e;

  // Time base
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] now_q, now_d;
  logic          tick;

  // Per-slot state and entry timestamps
  slot_state_e   state_q [SLOTS];
  slot_state_e   state_d [SLOTS];
  logic [TW-1:0] entry_q [SLOTS];
  logic [TW-1:0] entry_d [SLOTS];

  // Registered results
  logic              dur_valid_q, dur_valid_d;
  logic [SLOT_W-1:0] dur_slot_q,  dur_slot_d;
  logic [TW-1:0]     duration_q,  duration_d;
  logic              dur_sat_q,   dur_sat_d;
  logic              err_q,       err_d;

  // Loop temporaries for event decode
  logic enter_hit, exit_hit;
  logic enter_legal, exit_legal;

  // Prescaler and time-base next state
  // NOTE: every always_comb output is assigned on all paths (here and below via
  // defaults first) so no latch is inferred.
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + 1'b1;
    now_d   = tick ? now_q + 1'b1 : now_q;
  end

  // Per-slot FSM next state, exit result and error decode
  always_comb begin
    dur_valid_d = 1'b0;
    dur_slot_d  = dur_slot_q;
    duration_d  = duration_q;
    dur_sat_d   = dur_sat_q;
    err_d       = 1'b0;
    enter_hit   = 1'b0;
    exit_hit    = 1'b0;
    enter_legal = 1'b0;
    exit_legal  = 1'b0;

    for (int i = 0; i < SLOTS; i++) begin
      state_d[i] = state_q[i];
      entry_d[i] = entry_q[i];
      exit_hit   = bus.exit_valid  && (bus.exit_slot  == SLOT_W'(i));
      enter_hit  = bus.enter_valid && (bus.enter_slot == SLOT_W'(i));
      if (exit_hit)  exit_legal  = 1'b1;
      if (enter_hit) enter_legal = 1'b1;

      // Exit is evaluated first so a same-cycle re-entry reports the old stay.
      if (exit_hit) begin
        if (state_q[i] == FREE) begin
          err_d = 1'b1;
        end else begin
          dur_valid_d = 1'b1;
          dur_slot_d  = SLOT_W'(i);
          if (state_q[i] == SAT) begin
            duration_d = '1;
            dur_sat_d  = 1'b1;
          end else begin
            duration_d = now_q - entry_q[i];
            dur_sat_d  = 1'b0;
          end
          state_d[i] = FREE;
        end
      end

      if (enter_hit) begin
        if (state_d[i] == FREE) begin
          state_d[i] = OCC;
          entry_d[i] = now_q;
        end else begin
          err_d = 1'b1;
        end
      end else if (state_d[i] == OCC && tick && now_d == entry_q[i]) begin
        // The coming tick would make the elapsed time alias back to zero.
        state_d[i] = SAT;
      end
    end

    // Slot indices beyond SLOTS match no slot above.
    if (bus.exit_valid  && !exit_legal)  err_d = 1'b1;
    if (bus.enter_valid && !enter_legal) err_d = 1'b1;
  end

  // Time base registers
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      now_q   <= '0;
    end else begin
      presc_q <= presc_d;
      now_q   <= now_d;
    end
  end

  // Slot state and entry timestamp registers
  // NOTE: the timestamp array is reset as well; it is small and a defined value
  // keeps post-reset behaviour deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        state_q[i] <= FREE;
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        state_q[i] <= state_d[i];
        entry_q[i] <= entry_d[i];
      end
    end
  end

  // Result and error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dur_valid_q <= 1'b0;
      dur_slot_q  <= '0;
      duration_q  <= '0;
      dur_sat_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      dur_valid_q <= dur_valid_d;
      dur_slot_q  <= dur_slot_d;
      duration_q  <= duration_d;
      dur_sat_q   <= dur_sat_d;
      err_q       <= err_d;
    end
  end

  // Occupancy view and output drive
  always_comb begin
    bus.occupied = '0;
    for (int i = 0; i < SLOTS; i++) begin
      bus.occupied[i] = (state_q[i] != FREE);
    end
  end

  assign bus.now       = now_q;
  assign bus.dur_valid = dur_valid_q;
  assign bus.dur_slot  = dur_slot_q;
  assign bus.duration  = duration_q;
  assign bus.dur_sat   = dur_sat_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_parking_time_tracker.sv
// Directed bench for parking_time_tracker: a TICK_DIV=1, 4-slot instance for
// the main scenarios and a TICK_DIV=4, 3-slot instance for prescaling,
// out-of-range slots and asynchronous reset.
module tb_parking_time_tracker;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst4 = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  parking_time_tracker_if #(.TW(8), .SLOTS(4), .SLOT_W(2)) bus  ();
  parking_time_tracker_if #(.TW(8), .SLOTS(3), .SLOT_W(2)) bus4 ();

  parking_time_tracker #(.TW(8), .SLOTS(4), .SLOT_W(2), .TICK_DIV(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  parking_time_tracker #(.TW(8), .SLOTS(3), .SLOT_W(2), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4)
  );

  // Wait (bounded) for a negedge where the main instance shows now == t.
  task automatic wait_now(input logic [7:0] t);
    bit hit = 1'b0;
    for (int k = 0; k < 600 && !hit; k++) begin
      @(negedge clk);
      if (bus.now == t) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL wait_now: now=%0d, required %0d within 600 cycles", bus.now, t);
    end
  endtask

  // One-cycle event on the main instance; returns at the negedge where the
  // registered result is visible.
  task automatic drive(input bit en, input logic [1:0] es, input bit ex, input logic [1:0] xs);
    bus.enter_valid = en; bus.enter_slot = es;
    bus.exit_valid  = ex; bus.exit_slot  = xs;
    @(negedge clk);
    bus.enter_valid = 1'b0; bus.exit_valid = 1'b0;
  endtask

  task automatic drive4(input bit en, input logic [1:0] es, input bit ex, input logic [1:0] xs);
    bus4.enter_valid = en; bus4.enter_slot = es;
    bus4.exit_valid  = ex; bus4.exit_slot  = xs;
    @(negedge clk);
    bus4.enter_valid = 1'b0; bus4.exit_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.now !== 8'd0) begin n_fail++; $display("FAIL reset_now: got %0d, required 0", bus.now); end
    n_checks++; if (bus.occupied !== 4'b0000) begin n_fail++; $display("FAIL reset_occupied: got %b, required 0000", bus.occupied); end
    n_checks++; if (bus.dur_valid !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: dur_valid=%b err=%b, required 0 0", bus.dur_valid, bus.err); end
    n_checks++; if (bus.duration !== 8'd0 || bus.dur_sat !== 1'b0) begin n_fail++; $display("FAIL reset_duration: got %0d sat=%b, required 0 0", bus.duration, bus.dur_sat); end
    rst  = 1'b0;
    rst4 = 1'b0;
  endtask

  task automatic test_basic();
    wait_now(8'd5);
    drive(1'b1, 2'd0, 1'b0, 2'd0);
    wait_now(8'd12);
    drive(1'b0, 2'd0, 1'b1, 2'd0);
    n_checks++; if (bus.dur_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b, required 1", bus.dur_valid); end
    n_checks++; if (bus.dur_slot !== 2'd0) begin n_fail++; $display("FAIL basic_slot: got %0d, required 0", bus.dur_slot); end
    n_checks++; if (bus.duration !== 8'd7 || bus.dur_sat !== 1'b0) begin n_fail++; $display("FAIL basic_duration: got %0d sat=%b, required 7 0", bus.duration, bus.dur_sat); end
    n_checks++; if (bus.occupied[0] !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL basic_occ_err: occ0=%b err=%b, required 0 0", bus.occupied[0], bus.err); end
    @(negedge clk);
    n_checks++; if (bus.dur_valid !== 1'b0 || bus.duration !== 8'd7) begin n_fail++; $display("FAIL basic_pulse_hold: dur_valid=%b duration=%0d, required 0 7", bus.dur_valid, bus.duration); end
  endtask

  task automatic test_wrap();
    wait_now(8'd250);
    drive(1'b1, 2'd3, 1'b0, 2'd0);
    wait_now(8'd4);
    drive(1'b0, 2'd0, 1'b1, 2'd3);
    n_checks++; if (bus.dur_valid !== 1'b1 || bus.dur_slot !== 2'd3 || bus.duration !== 8'd10) begin n_fail++; $display("FAIL wrap_duration: valid=%b slot=%0d dur=%0d, required 1 3 10", bus.dur_valid, bus.dur_slot, bus.duration); end
  endtask

  task automatic test_saturate();
    wait_now(8'd3);
    drive(1'b1, 2'd1, 1'b0, 2'd0);
    repeat (299) @(negedge clk);
    drive(1'b0, 2'd0, 1'b1, 2'd1);
    n_checks++; if (bus.dur_valid !== 1'b1 || bus.dur_slot !== 2'd1) begin n_fail++; $display("FAIL sat_valid: valid=%b slot=%0d, required 1 1", bus.dur_valid, bus.dur_slot); end
    n_checks++; if (bus.duration !== 8'd255 || bus.dur_sat !== 1'b1) begin n_fail++; $display("FAIL sat_duration: got %0d sat=%b, required 255 1", bus.duration, bus.dur_sat); end
    wait_now(8'd100);
    drive(1'b1, 2'd1, 1'b0, 2'd0);
    wait_now(8'd102);
    drive(1'b0, 2'd0, 1'b1, 2'd1);
    n_checks++; if (bus.duration !== 8'd2 || bus.dur_sat !== 1'b0 || bus.dur_valid !== 1'b1) begin n_fail++; $display("FAIL sat_reentry: dur=%0d sat=%b valid=%b, required 2 0 1", bus.duration, bus.dur_sat, bus.dur_valid); end
  endtask

  task automatic test_same_slot();
    wait_now(8'd20);
    drive(1'b1, 2'd2, 1'b0, 2'd0);
    wait_now(8'd30);
    drive(1'b1, 2'd2, 1'b1, 2'd2);
    n_checks++; if (bus.dur_valid !== 1'b1 || bus.duration !== 8'd10 || bus.dur_slot !== 2'd2) begin n_fail++; $display("FAIL same_slot_dur: valid=%b dur=%0d slot=%0d, required 1 10 2", bus.dur_valid, bus.duration, bus.dur_slot); end
    n_checks++; if (bus.occupied[2] !== 1'b1 || bus.err !== 1'b0) begin n_fail++; $display("FAIL same_slot_occ: occ2=%b err=%b, required 1 0", bus.occupied[2], bus.err); end
    wait_now(8'd35);
    drive(1'b0, 2'd0, 1'b1, 2'd2);
    n_checks++; if (bus.duration !== 8'd5 || bus.occupied[2] !== 1'b0) begin n_fail++; $display("FAIL same_slot_reexit: dur=%0d occ2=%b, required 5 0", bus.duration, bus.occupied[2]); end
  endtask

  task automatic test_errors();
    drive(1'b0, 2'd0, 1'b1, 2'd1);
    n_checks++; if (bus.err !== 1'b1 || bus.dur_valid !== 1'b0) begin n_fail++; $display("FAIL err_free_exit: err=%b valid=%b, required 1 0", bus.err, bus.dur_valid); end
    @(negedge clk);
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width: err=%b, required 0", bus.err); end
    wait_now(8'd40);
    drive(1'b1, 2'd0, 1'b0, 2'd0);
    wait_now(8'd45);
    drive(1'b1, 2'd0, 1'b0, 2'd0);
    n_checks++; if (bus.err !== 1'b1 || bus.occupied !== 4'b0001) begin n_fail++; $display("FAIL err_occ_enter: err=%b occ=%b, required 1 0001", bus.err, bus.occupied); end
    wait_now(8'd50);
    drive(1'b0, 2'd0, 1'b1, 2'd0);
    n_checks++; if (bus.duration !== 8'd10 || bus.err !== 1'b0) begin n_fail++; $display("FAIL err_entry_kept: dur=%0d err=%b, required 10 0", bus.duration, bus.err); end
  endtask

  task automatic test_back_to_back();
    wait_now(8'd60);
    drive(1'b1, 2'd0, 1'b0, 2'd0);
    wait_now(8'd70);
    drive(1'b1, 2'd1, 1'b1, 2'd0);
    n_checks++; if (bus.dur_valid !== 1'b1 || bus.dur_slot !== 2'd0 || bus.duration !== 8'd10) begin n_fail++; $display("FAIL b2b_exit: valid=%b slot=%0d dur=%0d, required 1 0 10", bus.dur_valid, bus.dur_slot, bus.duration); end
    n_checks++; if (bus.occupied !== 4'b0010 || bus.err !== 1'b0) begin n_fail++; $display("FAIL b2b_occ: occ=%b err=%b, required 0010 0", bus.occupied, bus.err); end
    wait_now(8'd73);
    drive(1'b0, 2'd0, 1'b1, 2'd1);
    n_checks++; if (bus.dur_slot !== 2'd1 || bus.duration !== 8'd3 || bus.occupied !== 4'b0000) begin n_fail++; $display("FAIL b2b_second: slot=%0d dur=%0d occ=%b, required 1 3 0000", bus.dur_slot, bus.duration, bus.occupied); end
  endtask

  task automatic test_tick_div();
    logic [7:0] prev;
    logic [7:0] t;
    bit         seen = 1'b0;
    @(negedge clk);
    prev = bus4.now;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus4.now != prev) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL div_advance: now stuck at %0d, required a change within 10 clks", bus4.now); end
    t = bus4.now;
    repeat (3) @(negedge clk);
    n_checks++; if (bus4.now !== t) begin n_fail++; $display("FAIL div_hold: got %0d, required %0d", bus4.now, t); end
    @(negedge clk);
    n_checks++; if (bus4.now !== t + 8'd1) begin n_fail++; $display("FAIL div_step: got %0d, required %0d", bus4.now, t + 8'd1); end

    // Entry and exit inside one time unit: zero elapsed.
    drive4(1'b1, 2'd0, 1'b0, 2'd0);
    drive4(1'b0, 2'd0, 1'b1, 2'd0);
    n_checks++; if (bus4.dur_valid !== 1'b1 || bus4.duration !== 8'd0 || bus4.dur_sat !== 1'b0) begin n_fail++; $display("FAIL div_zero: valid=%b dur=%0d sat=%b, required 1 0 0", bus4.dur_valid, bus4.duration, bus4.dur_sat); end

    // Slot 3 does not exist on the 3-slot instance.
    drive4(1'b0, 2'd0, 1'b1, 2'd3);
    n_checks++; if (bus4.err !== 1'b1 || bus4.dur_valid !== 1'b0) begin n_fail++; $display("FAIL range_exit: err=%b valid=%b, required 1 0", bus4.err, bus4.dur_valid); end
    drive4(1'b1, 2'd3, 1'b0, 2'd0);
    n_checks++; if (bus4.err !== 1'b1 || bus4.occupied !== 3'b000) begin n_fail++; $display("FAIL range_enter: err=%b occ=%b, required 1 000", bus4.err, bus4.occupied); end

    // Asynchronous reset while a result is on the outputs.
    drive4(1'b1, 2'd1, 1'b0, 2'd0);
    n_checks++; if (bus4.occupied !== 3'b010) begin n_fail++; $display("FAIL rst_pre_occ: got %b, required 010", bus4.occupied); end
    repeat (5) @(negedge clk);
    bus4.exit_valid = 1'b1; bus4.exit_slot = 2'd1;
    @(posedge clk);
    #1;
    bus4.exit_valid = 1'b0;
    rst4 = 1'b1;
    #1;
    n_checks++; if (bus4.occupied !== 3'b000 || bus4.now !== 8'd0 || bus4.dur_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async: occ=%b now=%0d valid=%b, required 000 0 0", bus4.occupied, bus4.now, bus4.dur_valid); end
    @(negedge clk);
    rst4 = 1'b0;
    drive4(1'b0, 2'd0, 1'b1, 2'd1);
    n_checks++; if (bus4.err !== 1'b1 || bus4.dur_valid !== 1'b0) begin n_fail++; $display("FAIL rst_post_exit: err=%b valid=%b, required 1 0", bus4.err, bus4.dur_valid); end
  endtask

  initial begin
    bus.enter_valid  = 1'b0; bus.enter_slot  = 2'd0; bus.exit_valid  = 1'b0; bus.exit_slot  = 2'd0;
    bus4.enter_valid = 1'b0; bus4.enter_slot = 2'd0; bus4.exit_valid = 1'b0; bus4.exit_slot = 2'd0;
    test_reset();
    test_basic();
    test_wrap();
    test_saturate();
    test_same_slot();
    test_errors();
    test_back_to_back();
    test_tick_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule
